// File: rtl/cpu_pkg.sv
// Shared constants and the IF/ID payload type for the MIPS pipeline.
package cpu_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned IMEM_IDX_MSB = 9;
  localparam int unsigned IMEM_IDX_LSB = 2;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0040_0000;
  localparam logic [WORD_W-1:0] NOP_WORD         = 32'h0000_0000;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc4;
    logic [WORD_W-1:0] instr;
    logic              valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold, hold beats load.
// The same pattern is reused by the later pipeline registers.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   i_bubble,
  input  logic   i_hold,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  // A bubble keeps pc/pc4 of the squashed slot so it stays visible when debugging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '{pc: '0, pc4: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (i_bubble) begin
      r_q <= '{pc: i_d.pc, pc4: i_d.pc4, instr: NOP_INSTR, valid: 1'b0};
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC mux and IF/ID register.
// Optional IF_FETCH_PERF_EN adds saturating fetch/bubble counters.
module if_fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [WORD_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_instr_i,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_bubble_cnt_o,
`endif
  output logic [31:0] if_id_pc_o,
  output logic [31:0] if_id_pc4_o,
  output logic [31:0] if_id_instr_o,
  output logic        if_id_valid_o
);

  logic [WORD_W-1:0] r_pc;
  logic [WORD_W-1:0] w_pc4;
  logic [WORD_W-1:0] w_redirect_pc;
  logic              w_bubble;
  if_id_t            w_if_id_d;
  if_id_t            w_if_id_q;

  assign w_pc4         = r_pc + WORD_W'(4);
  assign w_redirect_pc = redirect_pc_i & ~WORD_W'(3);
  assign w_bubble      = redirect_valid_i | flush_i;

  // Redirect overrides stall; sequential fetch wraps modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid_i) begin
      r_pc <= w_redirect_pc;
    end else if (!stall_i) begin
      r_pc <= w_pc4;
    end
  end

  assign imem_addr_o = r_pc;
  assign w_if_id_d   = '{pc: r_pc, pc4: w_pc4, instr: imem_instr_i, valid: 1'b1};

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .i_bubble(w_bubble),
    .i_hold  (stall_i),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

  assign if_id_pc_o    = w_if_id_q.pc;
  assign if_id_pc4_o   = w_if_id_q.pc4;
  assign if_id_instr_o = w_if_id_q.instr;
  assign if_id_valid_o = w_if_id_q.valid;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_bubble_cnt;

  // Stall cycles load nothing new, so they count toward neither counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (!w_bubble && !stall_i && (r_fetch_cnt != '1)) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_bubble && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt_o  = r_fetch_cnt;
  assign perf_bubble_cnt_o = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage with a behavioural ROM.
module tb_if_fetch_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_instr_i;
  logic [31:0] if_id_pc_o;
  logic [31:0] if_id_pc4_o;
  logic [31:0] if_id_instr_o;
  logic        if_id_valid_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_bubble_cnt_o;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0]  rom [256];
  logic [128:0] obs;
  logic [128:0] exp_v;

  always #5 clk = ~clk;

  assign imem_instr_i = rom[imem_addr_o[IMEM_IDX_MSB:IMEM_IDX_LSB]];

  if_fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i   (redirect_pc_i),
    .imem_addr_o     (imem_addr_o),
    .imem_instr_i    (imem_instr_i),
`ifdef IF_FETCH_PERF_EN
    .perf_fetch_cnt_o (perf_fetch_cnt_o),
    .perf_bubble_cnt_o(perf_bubble_cnt_o),
`endif
    .if_id_pc_o      (if_id_pc_o),
    .if_id_pc4_o     (if_id_pc4_o),
    .if_id_instr_o   (if_id_instr_o),
    .if_id_valid_o   (if_id_valid_o)
  );

  function automatic logic [128:0] snap();
    return {imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    redirect_valid_i = 1'b0; redirect_pc_i = '0;
    tick(); tick();
    obs = snap(); exp_v = {32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, exp_v); end
    reset = 1'b0;
    #1;
    obs = snap();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL reset_release got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_seq_and_stall();
    tick(); obs = snap();
    exp_v = {32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'h2405_0000, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL seq1 got=%h want=%h", obs, exp_v); end
    tick(); obs = snap();
    exp_v = {32'h0040_0008, 32'h0040_0004, 32'h0040_0008, 32'h2407_0200, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL seq2 got=%h want=%h", obs, exp_v); end
    stall_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(); obs = snap();
      total++;
      if (obs !== exp_v) begin bad++; $display("FAIL stall_hold%0d got=%h want=%h", i, obs, exp_v); end
    end
    stall_i = 1'b0;
    tick(); obs = snap();
    exp_v = {32'h0040_000C, 32'h0040_0008, 32'h0040_000C, 32'h0000_2020, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL resume1 got=%h want=%h", obs, exp_v); end
    tick(); obs = snap();
    exp_v = {32'h0040_0010, 32'h0040_000C, 32'h0040_0010, 32'h0005_4021, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL resume2 got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_redirect();
    tick(); tick(); tick(); obs = snap();
    exp_v = {32'h0040_001C, 32'h0040_0018, 32'h0040_001C, 32'h3C00_0006, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pre_redirect got=%h want=%h", obs, exp_v); end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0040_0010;
    tick(); obs = snap();
    redirect_valid_i = 1'b0;
    exp_v = {32'h0040_0010, 32'h0040_001C, 32'h0040_0020, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redirect_bubble got=%h want=%h", obs, exp_v); end
    tick(); obs = snap();
    exp_v = {32'h0040_0014, 32'h0040_0010, 32'h0040_0014, 32'h3C00_0004, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redirect_target got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_redirect_stall();
    redirect_valid_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h0040_0137;
    tick(); obs = snap();
    redirect_valid_i = 1'b0; stall_i = 1'b0;
    exp_v = {32'h0040_0134, 32'h0040_0014, 32'h0040_0018, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redir_stall got=%h want=%h", obs, exp_v); end
    tick(); obs = snap();
    exp_v = {32'h0040_0138, 32'h0040_0134, 32'h0040_0138, 32'h3C00_004D, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL redir_stall_next got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_flush();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0040_0040;
    tick(); redirect_valid_i = 1'b0;
    flush_i = 1'b1;
    tick(); obs = snap();
    flush_i = 1'b0;
    exp_v = {32'h0040_0044, 32'h0040_0040, 32'h0040_0044, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush got=%h want=%h", obs, exp_v); end
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0040_0040;
    tick(); redirect_valid_i = 1'b0;
    flush_i = 1'b1; stall_i = 1'b1;
    tick(); obs = snap();
    flush_i = 1'b0; stall_i = 1'b0;
    exp_v = {32'h0040_0040, 32'h0040_0040, 32'h0040_0044, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush_stall got=%h want=%h", obs, exp_v); end
    tick(); obs = snap();
    exp_v = {32'h0040_0044, 32'h0040_0040, 32'h0040_0044, 32'h3C00_0010, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL flush_resume got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_wrap();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
    tick(); redirect_valid_i = 1'b0;
    tick(); obs = snap();
    exp_v = {32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_0000, 32'h3C00_00FF, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap got=%h want=%h", obs, exp_v); end
    tick(); obs = snap();
    exp_v = {32'h0000_0004, 32'h0000_0000, 32'h0000_0004, 32'h2405_0000, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL wrap_next got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_reset_mid_stall();
    redirect_valid_i = 1'b1; redirect_pc_i = 32'h0040_0050;
    tick(); redirect_valid_i = 1'b0;
    stall_i = 1'b1;
    tick(); obs = snap();
    exp_v = {32'h0040_0050, 32'h0000_0004, 32'h0000_0008, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL stall_before_reset got=%h want=%h", obs, exp_v); end
    #2 reset = 1'b1;
    #1 obs = snap();
    exp_v = {32'h0040_0000, 32'h0, 32'h0, 32'h0, 1'b0};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, exp_v); end
`ifdef IF_FETCH_PERF_EN
    total++;
    if ({perf_fetch_cnt_o, perf_bubble_cnt_o} !== 64'h0) begin
      bad++;
      $display("FAIL perf_reset got=%h/%h want=0/0", perf_fetch_cnt_o, perf_bubble_cnt_o);
    end
`endif
    tick();
    reset = 1'b0; stall_i = 1'b0;
    tick(); obs = snap();
    exp_v = {32'h0040_0004, 32'h0040_0000, 32'h0040_0004, 32'h2405_0000, 1'b1};
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL post_reset got=%h want=%h", obs, exp_v); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 32'h3C00_0000 | 32'(i);
    rom[0] = 32'h2405_0000;
    rom[1] = 32'h2407_0200;
    rom[2] = 32'h0000_2020;
    rom[3] = 32'h0005_4021;
    test_reset();
    test_seq_and_stall();
    test_redirect();
    test_redirect_stall();
    test_flush();
    test_wrap();
    test_reset_mid_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
